// File: rtl/shifter_pkg.sv
// Shared types for the sequential shift unit: operation modes and FSM states.
package shifter_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step in the selected mode, plus the bit that leaves the word.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  shift_mode_t      mode,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_next,
    output logic             bit_out
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        r_next  = r;
        bit_out = 1'b0;
        case (mode)
            LSL: begin
                r_next  = {r[WIDTH-2:0], 1'b0};
                bit_out = r[WIDTH-1];
            end
            LSR: begin
                r_next  = {1'b0, r[WIDTH-1:1]};
                bit_out = r[0];
            end
            ASR: begin
                r_next  = {r[WIDTH-1], r[WIDTH-1:1]};
                bit_out = r[0];
            end
            ROL: begin
                r_next  = {r[WIDTH-2:0], r[WIDTH-1]};
                bit_out = r[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one position per clock, start/busy/done handshake.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    shift_state_t     r_state;
    shift_state_t     w_state_next;
    shift_mode_t      r_mode;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_cout;
    logic             r_zero;
    logic [WIDTH-1:0] w_r_next;
    logic             w_bit_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode    (r_mode),
        .r       (r_work),
        .r_next  (w_r_next),
        .bit_out (w_bit_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The count is tested for zero before decrementing, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= LSL;
            r_work <= '0;
            r_cnt  <= '0;
            r_cout <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= a;
                        r_mode <= shift_mode_t'(mode);
                        r_cnt  <= shamt;
                        r_cout <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= w_r_next;
                        r_cout <= w_bit_out;
                        r_cnt  <= r_cnt - CNT_ONE;
                    end else begin
                        r_zero <= (r_work == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign result = r_work;
    assign cout   = r_cout;
    assign zero   = r_zero;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised self-checking bench for seq_shifter against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W   = 8;
    localparam int SW  = 3;
    localparam int MAX_WAIT = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  a;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shifter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: whole-word shift by s, with the last departing bit read directly from the operand.
    function automatic void model(input logic [W-1:0] op, input logic [1:0] md, input int s,
                                  output logic [W-1:0] res, output logic co);
        logic signed [W-1:0] sop;
        sop = op;
        res = op;
        co  = 1'b0;
        if (s != 0) begin
            case (md)
                2'd0: begin res = op << s;  co = op[W-s]; end
                2'd1: begin res = op >> s;  co = op[s-1]; end
                2'd2: begin res = sop >>> s; co = op[s-1]; end
                default: begin res = (op << s) | (op >> (W - s)); co = op[W-s]; end
            endcase
        end
    endfunction

    // Launch one operation, scramble the inputs after acceptance, then check latency, busy and flags.
    task automatic run_op(input string tag, input logic [W-1:0] op, input logic [1:0] md,
                          input logic [SW-1:0] s);
        logic [W-1:0] exp_res;
        logic         exp_co;
        int           lat;
        int           busy_cyc;
        model(op, md, int'(s), exp_res, exp_co);
        @(negedge clk);
        a = op; mode = md; shamt = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); mode = 2'($urandom); shamt = SW'($urandom);
        lat = 0; busy_cyc = 0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, int'(s) + 1);
        check({tag, " busy_cycles"}, busy_cyc, int'(s) + 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " cout"}, cout, exp_co);
        check({tag, " zero"}, zero, exp_res == '0);
        check({tag, " busy_at_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " result_hold"}, result, exp_res);
    endtask

    initial begin
        logic [W-1:0] exp_res;
        logic         exp_co;
        logic [W-1:0] seen_res;
        int           pulses;

        rst = 1'b1; start = 1'b0; mode = 2'd0; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst result", result, 8'h00);
        check("rst cout", cout, 1'b0);
        check("rst zero", zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1_lsl", 8'h03, 2'd0, 3'd2);
        run_op("t2_asr", 8'hB4, 2'd2, 3'd3);
        run_op("t3_lsr", 8'h80, 2'd1, 3'd7);
        run_op("t3_rol", 8'h81, 2'd3, 3'd1);
        run_op("t4_zero", 8'h00, 2'd3, 3'd0);
        run_op("rol_full", 8'hA5, 2'd3, 3'd7);

        // Start pulsed during SHIFT must be ignored.
        model(8'h5A, 2'd0, 5, exp_res, exp_co);
        @(negedge clk);
        a = 8'h5A; mode = 2'd0; shamt = 3'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; mode = 2'd1; shamt = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen_res = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin pulses++; seen_res = result; end
        end
        check("t5 done_pulses", pulses, 1);
        check("t5 result", seen_res, exp_res);
        check("t5 cout", cout, exp_co);

        // Reset in the middle of SHIFT aborts without a done pulse.
        @(negedge clk);
        a = 8'hC3; mode = 2'd0; shamt = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6 busy", busy, 1'b0);
        check("t6 done", done, 1'b0);
        check("t6 result", result, 8'h00);
        check("t6 cout", cout, 1'b0);
        check("t6 zero", zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("t6 no_done", pulses, 0);
        run_op("t6_after", 8'h96, 2'd2, 3'd4);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", W'($urandom), 2'($urandom), SW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
